ex_wb_skid_latch: RTL
=====================

Name: ex_wb_skid_latch

Overview:
Pipeline boundary between the execute stage and writeback, holding the uop WB is currently processing. Holds one uop in a main entry, which drives all WB_* outputs, plus a one-entry skid buffer. The skid buffer absorbs EX output while WB is stalled, so backpressure to EX is a registered signal. Also supports a WB-initiated flush for taken jumps and REPNE termination, and keeps a saturating stall-cycle counter.

Parameters:
CTRL_W, 32, width of the decoded control-store bundle (CS_*_WB bits) carried alongside the uop
CNT_W, 16, width of the stall-cycle performance counter

Ports:
CLK  in  1  clock; all state updates on rising edge
CLR  in  1  reset, synchronous, active-high
EX_V  in  1  EX presents a valid uop this cycle
EX_RESULT_A  in  32  primary result
EX_RESULT_C  in  32  secondary result / REPNE count
EX_NEIP  in  32  next EIP
EX_NCS  in  16  next CS
EX_FLAGS  in  32  flags computed by EX
EX_ld_gpr2  in  1  conditional GPR2 load request
EX_dcache_write  in  1  dcache write request
EX_d2_repne  in  1  REPNE prefix present
EX_CTRL  in  CTRL_W  control-store bundle for WB
WB_STALL  in  1  WB cannot consume the main entry this cycle
WB_FLUSH  in  1  WB redirect (taken EIP load or REPNE terminate); kill younger uops
EX_READY  out  1  latch can accept an EX uop this cycle (registered)
WB_V  out  1  main entry valid
WB_RESULT_A, WB_RESULT_C, WB_NEIP  out  32 each  main-entry payload
WB_NCS  out  16  main-entry payload
WB_FLAGS  out  32  main-entry payload
WB_ex_ld_gpr2_wb, WB_ex_dcache_write_wb, WB_d2_repne_wb  out  1 each  main-entry payload
WB_CTRL  out  CTRL_W  main-entry control bundle
STALL_CYCLES  out  CNT_W  count of cycles with WB_V and WB_STALL both high

Behaviour:
- State: main_v, main payload, skid_v, skid payload, stall counter.
- EX_READY = !skid_v, taken directly from a flop; there is no combinational path from WB_STALL or WB_FLUSH.
- accept = EX_V && EX_READY; the uop is captured at the clock edge.
- advance = !main_v || !WB_STALL.
- Priority each edge: CLR > WB_FLUSH > normal operation.
- CLR: main_v=0, skid_v=0, all payload=0, STALL_CYCLES=0, so EX_READY=1 on the next cycle. Reset mid-stall discards both entries.
- WB_FLUSH (not CLR):
  - main_v=0, skid_v=0; the incoming EX uop is dropped even if accept=1.
  - The uop in main on the flush cycle counts as retired by WB that cycle.
  - Payload registers may hold their old values.
  - Counter is unaffected except for the normal increment rule.
- Normal, advance=1:
  - If skid_v: main<=skid, skid_v<=0. No accept is possible because EX_READY=0.
  - Else: main<=EX payload, main_v<=accept.
- Normal, advance=0 (main_v=1, WB_STALL=1):
  - Main holds; all WB_* outputs stay bit-stable.
  - If accept: skid<=EX payload, skid_v<=1.
  - If skid is already valid: hold.
- Latency: EX uop to WB_V is 1 cycle with no stall. With a stall, strict order is kept: main, then skid, then new.
- Full: main_v=1, skid_v=1 gives EX_READY=0. Empty: both 0.
- A lost or duplicated uop is a bug. Throughput is 1 uop/cycle at steady state without stalls.
- STALL_CYCLES: increments when WB_V && WB_STALL, including on a flush cycle. It saturates at all-ones and does not wrap.
- WB_STALL while main_v=0 is ignored (advance=1) and does not count.

Test Plan:
- CLR for 2 cycles, then EX_V=1 with RESULT_A=0x11111111 -> the next cycle shows WB_V=1, WB_RESULT_A=0x11111111; after reset, EX_READY=1 and STALL_CYCLES=0.
- Back-to-back uops A=1, 2, 3, 4 with no stall -> WB_RESULT_A=1, 2, 3, 4 on consecutive cycles; EX_READY stays 1.
- Uop 5 in main, WB_STALL=1 for 3 cycles while EX sends 6 then holds 7:
  - 6 goes to skid; EX_READY=0 from the next cycle.
  - Main stays 5 and STALL_CYCLES=3.
  - After release, WB sees 5, 6, 7 in order with no loss or duplicate.
- Main=8, skid=9, WB_FLUSH=1 with EX_V=1 (uop 10) -> next cycle WB_V=0, EX_READY=1; uops 9 and 10 never appear on WB.
- CLR asserted while main and skid are both valid and WB_STALL=1 -> next cycle WB_V=0, EX_READY=1, STALL_CYCLES=0.
- With CNT_W=4, hold a stall for 20 cycles -> STALL_CYCLES reaches 15 and stays at 15.

Source files
------------

// File: rtl/ex_wb_skid_latch.sv
// ex_wb_skid_latch
// Execute-to-writeback pipeline boundary. The main entry holds the uop that
// WB is working on and drives every WB_* output. A one-entry skid buffer
// takes the EX uop that arrives while WB is stalled. Because of this buffer,
// the backpressure signal to EX (EX_READY) comes straight from a flop.
// A WB flush kills both entries. A saturating counter records the number of
// cycles in which WB stalled on a valid uop.

module ex_wb_skid_latch #(
    parameter int CTRL_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              CLR,

    // Execute-stage side
    input  logic              EX_V,
    input  logic [31:0]       EX_RESULT_A,
    input  logic [31:0]       EX_RESULT_C,
    input  logic [31:0]       EX_NEIP,
    input  logic [15:0]       EX_NCS,
    input  logic [31:0]       EX_FLAGS,
    input  logic              EX_ld_gpr2,
    input  logic              EX_dcache_write,
    input  logic              EX_d2_repne,
    input  logic [CTRL_W-1:0] EX_CTRL,

    // Writeback control
    input  logic              WB_STALL,
    input  logic              WB_FLUSH,

    // Backpressure to EX
    output logic              EX_READY,

    // Main-entry view for WB
    output logic              WB_V,
    output logic [31:0]       WB_RESULT_A,
    output logic [31:0]       WB_RESULT_C,
    output logic [31:0]       WB_NEIP,
    output logic [15:0]       WB_NCS,
    output logic [31:0]       WB_FLAGS,
    output logic              WB_ex_ld_gpr2_wb,
    output logic              WB_ex_dcache_write_wb,
    output logic              WB_d2_repne_wb,
    output logic [CTRL_W-1:0] WB_CTRL,

    // Performance counter
    output logic [CNT_W-1:0]  STALL_CYCLES
);

    // The complete uop payload that one entry carries.
    typedef struct packed {
        logic [31:0]       result_a;
        logic [31:0]       result_c;
        logic [31:0]       neip;
        logic [15:0]       ncs;
        logic [31:0]       flags;
        logic              ld_gpr2;
        logic              dcache_write;
        logic              d2_repne;
        logic [CTRL_W-1:0] ctrl;
    } uop_t;

    // Storage for the two entries
    uop_t             main_reg;
    uop_t             main_next;
    uop_t             skid_reg;
    uop_t             skid_next;
    logic             main_v_reg;
    logic             main_v_next;
    logic             skid_v_reg;
    logic             skid_v_next;

    // EX_READY lives in its own flop. It always equals !skid_v, but keeping
    // it separate means EX sees a pure register output.
    logic             ready_reg;
    logic             ready_next;

    // Stall-cycle counter
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] stall_cnt_next;

    // Per-cycle handshake terms
    uop_t             ex_uop;
    logic             accept;
    logic             advance;
    logic             stall_hit;
    logic             cnt_saturated;

    // Pack the incoming EX fields into a single payload word.
    always_comb begin
        ex_uop              = '0;
        ex_uop.result_a     = EX_RESULT_A;
        ex_uop.result_c     = EX_RESULT_C;
        ex_uop.neip         = EX_NEIP;
        ex_uop.ncs          = EX_NCS;
        ex_uop.flags        = EX_FLAGS;
        ex_uop.ld_gpr2      = EX_ld_gpr2;
        ex_uop.dcache_write = EX_dcache_write;
        ex_uop.d2_repne     = EX_d2_repne;
        ex_uop.ctrl         = EX_CTRL;
    end

    // An uop is accepted only while the registered ready is high. The main
    // entry advances when it is empty or when WB consumes it this cycle.
    // WB_STALL on an empty main entry therefore has no effect.
    assign accept        = EX_V && ready_reg;
    assign advance       = !main_v_reg || !WB_STALL;
    assign stall_hit     = main_v_reg && WB_STALL;
    assign cnt_saturated = &stall_cnt_reg;

    // Next state for both entries. A flush overrides normal movement.
    always_comb begin
        main_next   = main_reg;
        main_v_next = main_v_reg;
        skid_next   = skid_reg;
        skid_v_next = skid_v_reg;

        if (WB_FLUSH) begin
            // WB retires the current main uop and kills all younger uops,
            // including an EX uop accepted on this same edge. The payload
            // registers keep their contents. With both valids low, nothing
            // reads them.
            main_v_next = 1'b0;
            skid_v_next = 1'b0;
        end else if (advance) begin
            if (skid_v_reg) begin
                // The skidded uop is older than anything EX presents now, so
                // it moves up first. EX is blocked this cycle because
                // ready_reg is low.
                main_next   = skid_reg;
                main_v_next = 1'b1;
                skid_v_next = 1'b0;
            end else begin
                main_next   = ex_uop;
                main_v_next = accept;
            end
        end else begin
            // Main holds so the WB_* outputs stay stable. A new EX uop goes
            // into the skid buffer. If the skid buffer is already full,
            // ready_reg was low, so accept cannot be set here.
            if (accept) begin
                skid_next   = ex_uop;
                skid_v_next = 1'b1;
            end
        end
    end

    // Ready for the next cycle is the complement of the next skid valid.
    always_comb begin
        ready_next = !skid_v_next;
    end

    // Saturating stall counter. It also counts a flush cycle that arrives
    // while WB is stalled.
    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (stall_hit && !cnt_saturated) begin
            stall_cnt_next = stall_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Register update. CLR empties both entries and clears the payloads and
    // the counter.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            main_reg      <= '0;
            skid_reg      <= '0;
            main_v_reg    <= 1'b0;
            skid_v_reg    <= 1'b0;
            ready_reg     <= 1'b1;
            stall_cnt_reg <= '0;
        end else begin
            main_reg      <= main_next;
            skid_reg      <= skid_next;
            main_v_reg    <= main_v_next;
            skid_v_reg    <= skid_v_next;
            ready_reg     <= ready_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    // Every output comes directly from a register.
    assign EX_READY              = ready_reg;
    assign WB_V                  = main_v_reg;
    assign WB_RESULT_A           = main_reg.result_a;
    assign WB_RESULT_C           = main_reg.result_c;
    assign WB_NEIP               = main_reg.neip;
    assign WB_NCS                = main_reg.ncs;
    assign WB_FLAGS              = main_reg.flags;
    assign WB_ex_ld_gpr2_wb      = main_reg.ld_gpr2;
    assign WB_ex_dcache_write_wb = main_reg.dcache_write;
    assign WB_d2_repne_wb        = main_reg.d2_repne;
    assign WB_CTRL               = main_reg.ctrl;
    assign STALL_CYCLES          = stall_cnt_reg;

endmodule
